// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-side arbiter.
//   arb_state_t       : arbiter FSM states (IDLE, BURST)
//   DEFAULT_MAX_BURST : default maximum beats per grant
//   clog2_width()     : bit width needed to index/count, never less than 1
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEFAULT_MAX_BURST = 8;

    // Width of a field that must hold values 0..n-1; a 1-entry range still
    // needs one bit so the declaration stays legal.
    function automatic int clog2_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating-priority encoder.
//   req      in  N_REQ  request vector
//   last_idx in  IDX_W  index of the most recently served requester
//   grant    out N_REQ  one-hot winner (first request after last_idx, wrapping)
//   found    out 1      at least one request was present
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = clog2_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_idx,
    output logic [N_REQ-1:0] grant,
    output logic             found
);

    // Walk the candidates in priority order (last+1, last+2, ... last+N_REQ)
    // and keep the first one that is requesting. The last-served index itself
    // is visited last, so a lone requester can still be re-granted.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!found && req[k] && (k == (int'(last_idx) + i) % N_REQ)) begin
                    grant[k] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo_sync write port among N_REQ producers.
//   i_clk, i_rstn   clock, asynchronous active-low reset
//   i_valid/i_last  per-producer beat valid and end-of-burst marker
//   i_data          packed producer data, producer k in slice k
//   o_ready         per-producer ready (only the granted bit can be high)
//   i_fifo_full     FIFO o_full
//   i_fifo_fill     FIFO o_fill
//   o_fifo_wr       registered FIFO write strobe
//   o_fifo_data     registered FIFO write data
//   o_grant         one-hot current grant, 0 while idle
//   o_busy          high while a burst is in progress
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_BURST  = DEFAULT_MAX_BURST
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    input  logic [N_REQ-1:0]            i_valid,
    input  logic [N_REQ-1:0]            i_last,
    input  logic [N_REQ*DATA_WIDTH-1:0] i_data,
    output logic [N_REQ-1:0]            o_ready,
    input  logic                        i_fifo_full,
    input  logic [ADDR_WIDTH:0]         i_fifo_fill,
    output logic                        o_fifo_wr,
    output logic [DATA_WIDTH-1:0]       o_fifo_data,
    output logic [N_REQ-1:0]            o_grant,
    output logic                        o_busy
);

    localparam int IDX_W = clog2_width(N_REQ);
    localparam int CNT_W = clog2_width(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
    // FIFO depth expressed with one guard bit above the fill width.
    localparam logic [ADDR_WIDTH+1:0] DEPTH = {1'b0, 1'b1, {ADDR_WIDTH{1'b0}}};

    arb_state_t           state;
    logic [IDX_W-1:0]     last_idx;
    logic [CNT_W-1:0]     beat_cnt;

    logic [N_REQ-1:0]     pick_grant;
    logic                 pick_found;
    logic [IDX_W-1:0]     grant_idx;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                 sel_last;
    logic [ADDR_WIDTH+1:0] fill_ahead;
    logic                 space_block;
    logic                 accept;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req      (i_valid),
        .last_idx (last_idx),
        .grant    (pick_grant),
        .found    (pick_found)
    );

    // The write registered last cycle has not reached o_fill yet, so it is
    // added in before comparing against the depth.
    assign fill_ahead  = {1'b0, i_fifo_fill} + {{(ADDR_WIDTH+1){1'b0}}, o_fifo_wr};
    assign space_block = i_fifo_full | (fill_ahead >= DEPTH);

    // Ready depends only on state, grant and FIFO space, never on i_valid.
    assign o_ready = ((state == BURST) && !space_block) ? o_grant : '0;
    assign accept  = |(o_ready & i_valid);
    assign sel_last = |(o_grant & i_last);

    // Decode the registered one-hot grant into an index and a data mux.
    always_comb begin
        grant_idx = '0;
        sel_data  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (o_grant[k]) begin
                grant_idx = IDX_W'(k);
                sel_data  = i_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= IDLE;
            last_idx    <= IDX_W'(N_REQ - 1);
            beat_cnt    <= '0;
            o_fifo_wr   <= 1'b0;
            o_fifo_data <= '0;
            o_grant     <= '0;
            o_busy      <= 1'b0;
        end else begin
            o_fifo_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        o_grant <= pick_grant;
                        o_busy  <= 1'b1;
                        state   <= BURST;
                    end
                end
                BURST: begin
                    // A stalled producer simply holds the grant; nothing
                    // advances until the next accepted beat.
                    if (accept) begin
                        o_fifo_wr   <= 1'b1;
                        o_fifo_data <= sel_data;
                        if (sel_last || (beat_cnt == LAST_CNT)) begin
                            state    <= IDLE;
                            o_busy   <= 1'b0;
                            o_grant  <= '0;
                            last_idx <= grant_idx;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: producer models drive beats, the
// expected FIFO write data is queued on every handshake and compared when the
// arbiter emits o_fifo_wr; directed checks cover grant timing and throttling.
module tb_fifo_wr_arbiter;

    localparam int N_REQ      = 4;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 10;
    localparam int MAX_BURST  = 8;

    logic                        i_clk = 1'b0;
    logic                        i_rstn;
    logic [N_REQ-1:0]            i_valid;
    logic [N_REQ-1:0]            i_last;
    logic [N_REQ*DATA_WIDTH-1:0] i_data;
    logic [N_REQ-1:0]            o_ready;
    logic                        i_fifo_full;
    logic [ADDR_WIDTH:0]         i_fifo_fill;
    logic                        o_fifo_wr;
    logic [DATA_WIDTH-1:0]       o_fifo_data;
    logic [N_REQ-1:0]            o_grant;
    logic                        o_busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int wr_count     = 0;

    logic [DATA_WIDTH-1:0] exp_q[$];
    int                    grant_cycle_q[$];
    logic [N_REQ-1:0]      grant_val_q[$];
    logic [N_REQ-1:0]      prev_grant = '0;

    // Producer models: valid enable, beats remaining (-1 = endless), next data.
    logic                  m_valid[N_REQ];
    int                    m_left[N_REQ];
    logic [DATA_WIDTH-1:0] m_data[N_REQ];
    int                    hs_count[N_REQ];

    fifo_wr_arbiter #(
        .N_REQ      (N_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_valid     (i_valid),
        .i_last      (i_last),
        .i_data      (i_data),
        .o_ready     (o_ready),
        .i_fifo_full (i_fifo_full),
        .i_fifo_fill (i_fifo_fill),
        .o_fifo_wr   (o_fifo_wr),
        .o_fifo_data (o_fifo_data),
        .o_grant     (o_grant),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Scoreboard consumer and grant logger, sampled on the falling edge.
    always @(negedge i_clk) begin
        if (i_rstn === 1'b1) begin
            if (o_fifo_wr === 1'b1) begin
                wr_count++;
                if (exp_q.size() == 0)
                    checkOutput("unexpected_wr", 32'(o_fifo_wr), 32'd0);
                else
                    checkOutput("wr_data", o_fifo_data, exp_q.pop_front());
            end
            if (o_grant != prev_grant && o_grant != '0) begin
                grant_cycle_q.push_back(cyc);
                grant_val_q.push_back(o_grant);
            end
            prev_grant = o_grant;
        end else begin
            prev_grant = '0;
        end
    end

    task automatic driveInputs();
        for (int k = 0; k < N_REQ; k++) begin
            i_valid[k] = m_valid[k] && (m_left[k] != 0);
            i_last[k]  = (m_left[k] == 1);
            i_data[k*DATA_WIDTH +: DATA_WIDTH] = m_data[k];
        end
    endtask

    task automatic setProducer(input int k, input logic v, input int left,
                               input logic [DATA_WIDTH-1:0] base);
        m_valid[k] = v;
        m_left[k]  = left;
        m_data[k]  = base;
    endtask

    // Run n cycles starting at a falling edge: drive, record handshakes into
    // the scoreboard, advance the producer models after the rising edge.
    task automatic applyStimulus(input int n);
        logic [N_REQ-1:0] hs;
        repeat (n) begin
            driveInputs();
            #1;
            hs = i_valid & o_ready;
            for (int k = 0; k < N_REQ; k++)
                if (hs[k]) exp_q.push_back(m_data[k]);
            @(posedge i_clk);
            for (int k = 0; k < N_REQ; k++) begin
                if (hs[k]) begin
                    m_data[k] = m_data[k] + 1;
                    if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
                    hs_count[k]++;
                end
            end
            @(negedge i_clk);
        end
        driveInputs();
    endtask

    task automatic resetDut();
        i_rstn      = 1'b0;
        i_fifo_full = 1'b0;
        i_fifo_fill = '0;
        for (int k = 0; k < N_REQ; k++) begin
            setProducer(k, 1'b0, 0, '0);
            hs_count[k] = 0;
        end
        driveInputs();
        exp_q.delete();
        grant_cycle_q.delete();
        grant_val_q.delete();
        wr_count = 0;
        repeat (2) @(negedge i_clk);
        i_rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values and a single 3-beat burst from producer 0.
        resetDut();
        #1;
        checkOutput("rst_ready", 32'(o_ready), 32'd0);
        checkOutput("rst_wr", 32'(o_fifo_wr), 32'd0);
        checkOutput("rst_data", o_fifo_data, 32'd0);
        checkOutput("rst_grant", 32'(o_grant), 32'd0);
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        setProducer(0, 1'b1, 3, 32'hA0);
        applyStimulus(1);
        checkOutput("t1_grant", 32'(o_grant), 32'h1);
        checkOutput("t1_busy", 32'(o_busy), 32'd1);
        checkOutput("t1_ready", 32'(o_ready), 32'h1);
        applyStimulus(3);
        checkOutput("t1_end_grant", 32'(o_grant), 32'd0);
        checkOutput("t1_end_busy", 32'(o_busy), 32'd0);
        checkOutput("t1_beats", 32'(hs_count[0]), 32'd3);
        applyStimulus(2);
        checkOutput("t1_writes", 32'(wr_count), 32'd3);
        checkOutput("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // All producers continuously valid: 8-beat grants 0,1,2,3,0 spaced
        // by one idle cycle (9 cycles grant to grant).
        resetDut();
        for (int k = 0; k < N_REQ; k++)
            setProducer(k, 1'b1, -1, 32'((k + 1) << 24));
        applyStimulus(37);
        #1;
        checkOutput("t2_grant_count", 32'(grant_val_q.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < grant_val_q.size())
                checkOutput($sformatf("t2_grant%0d", i), 32'(grant_val_q[i]),
                            32'(1 << (i % N_REQ)));
        for (int i = 1; i < 5; i++)
            if (i < grant_cycle_q.size())
                checkOutput($sformatf("t2_spacing%0d", i),
                            32'(grant_cycle_q[i] - grant_cycle_q[i-1]), 32'd9);
        for (int k = 0; k < N_REQ; k++)
            checkOutput($sformatf("t2_beats%0d", k), 32'(hs_count[k]), 32'(MAX_BURST));
        checkOutput("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // FIFO one entry from full: one beat, then blocked while full.
        resetDut();
        i_fifo_fill = 11'd1023;
        setProducer(1, 1'b1, -1, 32'h1100_0000);
        applyStimulus(1);
        checkOutput("t3_ready_space", 32'(o_ready), 32'h2);
        applyStimulus(1);
        checkOutput("t3_ready_inflight", 32'(o_ready), 32'd0);
        applyStimulus(1);
        i_fifo_fill = 11'd1024;
        i_fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("t3_ready_full", 32'(o_ready), 32'd0);
            checkOutput("t3_no_wr_full", 32'(o_fifo_wr), 32'd0);
            applyStimulus(1);
        end
        checkOutput("t3_one_beat", 32'(hs_count[1]), 32'd1);
        i_fifo_fill = 11'd1000;
        i_fifo_full = 1'b0;
        #1;
        checkOutput("t3_ready_resume", 32'(o_ready), 32'h2);
        applyStimulus(3);
        m_valid[1] = 1'b0;
        applyStimulus(1);
        checkOutput("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // Granted producer stalls for 5 cycles while producer 2 waits.
        resetDut();
        setProducer(0, 1'b1, -1, 32'h0400_0000);
        setProducer(2, 1'b1, -1, 32'h0600_0000);
        applyStimulus(1);
        checkOutput("t4_grant", 32'(o_grant), 32'h1);
        applyStimulus(2);
        m_valid[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("t4_grant_held", 32'(o_grant), 32'h1);
            checkOutput("t4_ready_p2", 32'(o_ready[2]), 32'd0);
            if (i > 0) checkOutput("t4_no_wr", 32'(o_fifo_wr), 32'd0);
            applyStimulus(1);
        end
        checkOutput("t4_no_wr_end", 32'(o_fifo_wr), 32'd0);
        m_valid[0] = 1'b1;
        applyStimulus(6);
        checkOutput("t4_burst_done", 32'(o_grant), 32'd0);
        checkOutput("t4_p2_waited", 32'(hs_count[2]), 32'd0);
        applyStimulus(1);
        checkOutput("t4_next_grant", 32'(o_grant), 32'h4);
        for (int k = 0; k < N_REQ; k++) m_valid[k] = 1'b0;
        applyStimulus(1);
        checkOutput("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset asserted mid-burst, then producers 1 and 3 compete.
        resetDut();
        setProducer(0, 1'b1, -1, 32'h0C00_0000);
        applyStimulus(4);
        #2;
        i_rstn = 1'b0;
        #1;
        checkOutput("t5_rst_ready", 32'(o_ready), 32'd0);
        checkOutput("t5_rst_wr", 32'(o_fifo_wr), 32'd0);
        checkOutput("t5_rst_data", o_fifo_data, 32'd0);
        checkOutput("t5_rst_grant", 32'(o_grant), 32'd0);
        checkOutput("t5_rst_busy", 32'(o_busy), 32'd0);
        checkOutput("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        setProducer(0, 1'b0, 0, '0);
        setProducer(1, 1'b1, -1, 32'h0D00_0000);
        setProducer(3, 1'b1, -1, 32'h0F00_0000);
        driveInputs();
        repeat (2) @(negedge i_clk);
        #1;
        checkOutput("t5_grant_in_rst", 32'(o_grant), 32'd0);
        i_rstn = 1'b1;
        applyStimulus(1);
        checkOutput("t5_first_grant", 32'(o_grant), 32'h2);
        checkOutput("t5_first_ready", 32'(o_ready), 32'h2);
        applyStimulus(2);
        for (int k = 0; k < N_REQ; k++) m_valid[k] = 1'b0;
        applyStimulus(2);
        checkOutput("t5_final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
